// File: rtl/sisc_pkg.sv
// Shared constants and types for the SISC instruction-fetch slice.
package sisc_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned PC_W_DEF = 16;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sisc_fetch_buf.sv
// Prefetch FIFO of {pc, instr}; head, count and empty/full are registered.
// flush beats push and pop.
module fetch_buf
    import sisc_pkg::*;
#(
    parameter  int unsigned PC_W  = PC_W_DEF,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               push,
    input  logic [PC_W-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic [PC_W-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic               head_valid,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);

    logic [PC_W-1:0]    pc_mem  [DEPTH];
    logic [INSTR_W-1:0] ins_mem [DEPTH];

    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               do_push, do_pop;
    logic [PC_W-1:0]    hpc_nxt;
    logic [INSTR_W-1:0] hins_nxt;

    // Next pointers/count and the head as it will look after this edge.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        rd_nxt   = rd_ptr + PTR_W'(do_pop);
        wr_nxt   = wr_ptr + PTR_W'(do_push);
        cnt_nxt  = count + CNT_W'(do_push) - CNT_W'(do_pop);
        hpc_nxt  = '0;
        hins_nxt = NOP_WORD;
        if (cnt_nxt != '0) begin
            // Head slot being written this edge: bypass the incoming word.
            if (do_push && (rd_nxt == wr_ptr)) begin
                hpc_nxt  = push_pc;
                hins_nxt = push_instr;
            end else begin
                hpc_nxt  = pc_mem[rd_nxt];
                hins_nxt = ins_mem[rd_nxt];
            end
        end
        if (flush) begin
            rd_nxt   = '0;
            wr_nxt   = '0;
            cnt_nxt  = '0;
            hpc_nxt  = '0;
            hins_nxt = NOP_WORD;
        end
    end

    // Pointer, count and registered head state.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            head_valid <= 1'b0;
            head_pc    <= '0;
            head_instr <= NOP_WORD;
        end else begin
            rd_ptr     <= rd_nxt;
            wr_ptr     <= wr_nxt;
            count      <= cnt_nxt;
            empty      <= (cnt_nxt == '0);
            full       <= (cnt_nxt == CNT_W'(DEPTH));
            head_valid <= (cnt_nxt != '0);
            head_pc    <= hpc_nxt;
            head_instr <= hins_nxt;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pc_mem[wr_ptr]  <= push_pc;
            ins_mem[wr_ptr] <= push_instr;
        end
    end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch: PC owner, single-outstanding imem requester,
// prefetch buffer and branch redirect/flush.
// Optional: FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int unsigned    PC_W     = PC_W_DEF,
    parameter int unsigned    DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_addr,
    input  logic               halt,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state, state_nxt;
    logic [PC_W-1:0]   fetch_pc, pc_nxt, addr_nxt;
    logic              req_nxt;
    logic              buf_push, buf_pop, buf_flush, buf_empty, buf_full;
    logic [CNT_W-1:0]  buf_count, cnt_after;

    fetch_buf #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_f      (rst_f),
        .push       (buf_push),
        .push_pc    (fetch_pc),
        .push_instr (imem_data),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .head_pc    (ir_pc),
        .head_instr (ir),
        .head_valid (ir_valid),
        .count      (buf_count),
        .empty      (buf_empty),
        .full       (buf_full)
    );

    // State, fetch PC and registered memory request outputs.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= pc_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
        end
    end

    // Next state and next fetch PC; redirect outranks ack.
    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        // Occupancy after this edge if the pending ack is pushed.
        cnt_after = buf_count + CNT_W'(1) - CNT_W'(buf_pop);
        case (state)
            IDLE: begin
                if (br_taken) begin
                    pc_nxt = br_addr;
                    if (!halt) state_nxt = REQ;
                end else if (!halt && (!buf_full || buf_pop)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (br_taken) begin
                    pc_nxt    = br_addr;
                    state_nxt = imem_ack ? (halt ? IDLE : REQ) : DROP;
                end else if (imem_ack) begin
                    pc_nxt    = fetch_pc + PC_W'(1);
                    state_nxt = (!halt && (cnt_after < CNT_W'(DEPTH))) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (br_taken) pc_nxt = br_addr;
                if (imem_ack) state_nxt = halt ? IDLE : REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer controls and next values of the request outputs.
    always_comb begin
        buf_flush = br_taken;
        buf_push  = (state == REQ) && imem_ack && !br_taken;
        buf_pop   = !buf_empty && ir_ready;
        req_nxt   = (state_nxt != IDLE);
        // While draining a stale request the old address must stay put.
        addr_nxt  = (state_nxt == DROP) ? imem_addr : pc_nxt;
    end

`ifdef FETCH_STALL_CNT_EN
    // Count cycles where downstream is ready but nothing is presented.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            stall_cnt <= '0;
        end else if (ir_ready && !ir_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed bench for sisc_fetch with a latency-programmable memory model.
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        br_taken;
    logic [15:0] br_addr;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;

    logic        w_req;
    logic [15:0] w_addr;
    logic        w_ack;
    logic [31:0] w_data;
    logic [31:0] w_ir;
    logic [15:0] w_ir_pc;
    logic        w_ir_valid;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] w_stall;
    logic [15:0] s0;
`endif

    int lat      = 0;
    int wait_cnt = 0;
    int total    = 0;
    int bad      = 0;

    always #5 clk = ~clk;

    // Memory model: ack after 'lat' waiting cycles, data tagged with address.
    always_comb imem_ack = imem_req && (wait_cnt >= lat);
    assign imem_data = {16'hC0DE, imem_addr};

    always_ff @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    // Zero-latency memory for the wrap instance.
    assign w_ack  = w_req;
    assign w_data = {16'hBEEF, w_addr};

    sisc_fetch #(.PC_W(16), .DEPTH(2), .RESET_PC(16'h0000)) u_dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .br_taken  (br_taken),
        .br_addr   (br_addr),
        .halt      (halt),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .ir_ready  (ir_ready)
    );

    sisc_fetch #(.PC_W(16), .DEPTH(2), .RESET_PC(16'hFFFF)) u_wrap (
        .clk       (clk),
        .rst_f     (rst_f),
        .br_taken  (1'b0),
        .br_addr   (16'h0000),
        .halt      (1'b0),
        .imem_req  (w_req),
        .imem_addr (w_addr),
        .imem_ack  (w_ack),
        .imem_data (w_data),
        .ir        (w_ir),
        .ir_pc     (w_ir_pc),
        .ir_valid  (w_ir_valid),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt (w_stall),
`endif
        .ir_ready  (1'b1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Hard stop in case something wedges the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e16;
        logic [15:0] last_pc;
        int          req_cycles;

        rst_f    = 1'b1;
        br_taken = 1'b0;
        br_addr  = 16'h0000;
        halt     = 1'b0;
        ir_ready = 1'b1;
        lat      = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_req",   32'(imem_req),  32'h0);
        check_eq("rst_addr",  32'(imem_addr), 32'h0);
        check_eq("rst_ir",    ir,             32'h0);
        check_eq("rst_ir_pc", 32'(ir_pc),     32'h0);
        check_eq("rst_valid", 32'(ir_valid),  32'h0);
        check_eq("rst_w_addr", 32'(w_addr),   32'h0000FFFF);
`ifdef FETCH_STALL_CNT_EN
        check_eq("rst_stall", 32'(stall_cnt), 32'h0);
`endif

        // Zero-latency streaming, plus wrap on the second instance.
        rst_f = 1'b0;
        @(negedge clk);
        check_eq("t1_req",   32'(imem_req),  32'h1);
        check_eq("t1_addr",  32'(imem_addr), 32'h0);
        check_eq("t1_nv",    32'(ir_valid),  32'h0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check_eq("t1_valid", 32'(ir_valid), 32'h1);
            check_eq("t1_pc",    32'(ir_pc),    32'(k - 2));
            check_eq("t1_ir",    ir,            {16'hC0DE, 16'(k - 2)});
            if (k <= 4) begin
                e16 = 16'hFFFF + 16'(k - 2);
                check_eq("wrap_pc", 32'(w_ir_pc), 32'(e16));
                check_eq("wrap_ir", w_ir,         {16'hBEEF, e16});
                check_eq("wrap_v",  32'(w_ir_valid), 32'h1);
            end
        end
`ifdef FETCH_STALL_CNT_EN
        check_eq("t1_stall",   32'(stall_cnt), 32'h2);
        check_eq("wrap_stall", 32'(w_stall),   32'h2);
`endif

        // Backpressure fills the buffer, then drains in order.
        rst_f    = 1'b1;
        ir_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_f = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t2_req_off", 32'(imem_req),  32'h0);
        check_eq("t2_addr",    32'(imem_addr), 32'h2);
        check_eq("t2_valid",   32'(ir_valid),  32'h1);
        check_eq("t2_pc0",     32'(ir_pc),     32'h0);
        check_eq("t2_ir0",     ir,             32'hC0DE0000);
        ir_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_eq("t2_dvalid", 32'(ir_valid), 32'h1);
            check_eq("t2_dpc",    32'(ir_pc),    32'(k));
        end

        // Redirect while a latency-3 request to 0x0005 is pending.
        rst_f = 1'b1;
        lat   = 3;
        repeat (2) @(negedge clk);
        rst_f = 1'b0;
        for (int i = 0; i < 200 && !(imem_req && imem_addr == 16'h0005); i++) @(negedge clk);
        check_eq("t3_reach5", 32'(imem_req && imem_addr == 16'h0005), 32'h1);
        check_eq("t3_pend",   32'(imem_ack), 32'h0);
        br_taken = 1'b1;
        br_addr  = 16'h0040;
        @(negedge clk);
        br_taken = 1'b0;
        check_eq("t3_drop_req",  32'(imem_req),  32'h1);
        check_eq("t3_drop_addr", 32'(imem_addr), 32'h5);
        check_eq("t3_flushed",   32'(ir_valid),  32'h0);
        for (int i = 0; i < 20 && imem_addr == 16'h0005; i++) @(negedge clk);
        check_eq("t3_new_addr", 32'(imem_addr), 32'h40);
        check_eq("t3_new_req",  32'(imem_req),  32'h1);
        for (int i = 0; i < 20 && !ir_valid; i++) @(negedge clk);
        check_eq("t3_first_pc", 32'(ir_pc), 32'h40);
        check_eq("t3_first_ir", ir,         32'hC0DE0040);

        // Redirect coincident with an ack and a pop.
        rst_f = 1'b1;
        lat   = 0;
        repeat (2) @(negedge clk);
        rst_f = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t4_pre_pc",  32'(ir_pc),    32'h2);
        check_eq("t4_pre_ack", 32'(imem_ack), 32'h1);
        br_taken = 1'b1;
        br_addr  = 16'h0080;
        @(negedge clk);
        br_taken = 1'b0;
        check_eq("t4_valid", 32'(ir_valid),  32'h0);
        check_eq("t4_ir",    ir,             32'h0);
        check_eq("t4_pc",    32'(ir_pc),     32'h0);
        check_eq("t4_req",   32'(imem_req),  32'h1);
        check_eq("t4_addr",  32'(imem_addr), 32'h80);
        @(negedge clk);
        check_eq("t4_tgt_pc", 32'(ir_pc),    32'h80);
        check_eq("t4_tgt_ir", ir,            32'hC0DE0080);
        check_eq("t4_tgt_v",  32'(ir_valid), 32'h1);

        // Halt with a fresh latency-2 request to 0x0081 outstanding.
        lat  = 2;
        halt = 1'b1;
        check_eq("t5_out_addr", 32'(imem_addr), 32'h81);
        req_cycles = 0;
        last_pc    = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ir_valid) last_pc = ir_pc;
            if (imem_req) req_cycles++;
        end
        check_eq("t5_req_cycles", 32'(req_cycles), 32'h2);
        check_eq("t5_last_pc",    32'(last_pc),    32'h81);
        check_eq("t5_drained",    32'(ir_valid),   32'h0);
        check_eq("t5_req_off",    32'(imem_req),   32'h0);
`ifdef FETCH_STALL_CNT_EN
        s0 = stall_cnt;
        repeat (5) @(negedge clk);
        check_eq("t5_stall", 32'(stall_cnt), 32'(s0 + 16'd5));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
